// File: rtl/disp_pkg.sv
// disp_pkg: shared states, slot sequence and data types for the display scan controller
package disp_pkg;

    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
    } disp_data_t;

    localparam int unsigned DEFAULT_REFRESH_DIV = 100000;
    localparam logic [3:0] DISP_BLANK = 4'd2;
    localparam logic [2:0] SLOT_LAST = 3'd5;
    // Slot index 0..5 maps to displays 0,1,4,5,6,7; displays 2 and 3 are never driven
    localparam logic [5:0][3:0] SLOT_SEQ = {4'd7, 4'd6, 4'd5, 4'd4, 4'd1, 4'd0};

    function automatic logic [3:0] slot_nibble(input logic [2:0] slot, input disp_data_t d);
        logic [7:0] sel;
        sel = slot[2] ? d.r : slot[1] ? d.b : d.a;
        return slot[0] ? sel[3:0] : sel[7:4];
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_tick_gen.sv
// tick_gen: free-running 0..DIV-1 prescaler with a one-cycle tick on the last count
module tick_gen
    import disp_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_REFRESH_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clr && cnt_q == LAST;
        cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexes A, B and result onto six 7-segment slots with frame-safe data loading
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic [7:0] result,
    output logic [3:0] disp_idx,
    output logic [3:0] nibble,
    output logic       position,
    output logic       frame_done
);

    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    disp_data_t active_q, active_d, pend_q, pend_d;
    logic       pend_v_q, pend_v_d;
    logic       load_ready_q, load_ready_d;
    logic       frame_done_q, frame_done_d;
    logic [3:0] disp_idx_q, disp_idx_d;
    logic [3:0] nibble_q, nibble_d;
    logic       position_q, position_d;
    logic       tick, tick_clr, enter, advance, boundary, apply, accept;

    assign tick_clr = state_q == IDLE;

    tick_gen #(.DIV(REFRESH_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Pending data only moves to the active copy between frames, so a frame never mixes loads
    always_comb begin
        enter        = state_q == IDLE && enable;
        advance      = state_q == SCAN && tick;
        boundary     = advance && slot_q == SLOT_LAST;
        apply        = enter || boundary;
        accept       = load_valid && load_ready_q;
        state_d      = enter ? SCAN : (boundary && !enable) ? IDLE : state_q;
        slot_d       = apply ? 3'd0 : advance ? slot_q + 3'd1 : slot_q;
        active_d     = (apply && pend_v_q) ? pend_q : active_q;
        pend_v_d     = accept ? 1'b1 : apply ? 1'b0 : pend_v_q;
        pend_d       = accept ? '{a: op_a, b: op_b, r: result} : pend_q;
        load_ready_d = !pend_v_d;
        frame_done_d = boundary;
        disp_idx_d   = state_q == SCAN ? SLOT_SEQ[slot_q] : DISP_BLANK;
        nibble_d     = state_q == SCAN ? slot_nibble(slot_q, active_q) : 4'd0;
        position_d   = state_q == SCAN && slot_q[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            load_ready_q <= 1'b1;
            frame_done_q <= 1'b0;
            disp_idx_q   <= DISP_BLANK;
            nibble_q     <= '0;
            position_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            load_ready_q <= load_ready_d;
            frame_done_q <= frame_done_d;
            disp_idx_q   <= disp_idx_d;
            nibble_q     <= nibble_d;
            position_q   <= position_d;
        end
    end

    assign load_ready = load_ready_q;
    assign frame_done = frame_done_q;
    assign disp_idx   = disp_idx_q;
    assign nibble     = nibble_q;
    assign position   = position_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed and random stimulus on two instances (DIV=4, DIV=1) against a time-based model
module tb_disp_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset, enable, load_valid;
    logic [7:0] op_a, op_b, result;
    logic [3:0] idx0, nib0, idx1, nib1;
    logic       pos0, fd0, rdy0, pos1, fd1, rdy1;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.REFRESH_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid), .load_ready(rdy0),
        .op_a(op_a), .op_b(op_b), .result(result),
        .disp_idx(idx0), .nibble(nib0), .position(pos0), .frame_done(fd0)
    );

    disp_scan_ctrl #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid), .load_ready(rdy1),
        .op_a(op_a), .op_b(op_b), .result(result),
        .disp_idx(idx1), .nibble(nib1), .position(pos1), .frame_done(fd1)
    );

    // Model: m_t counts cycles since scanning began; slot = (m_t / div) % 6, frame = 6*div cycles
    int          div[2] = '{4, 1};
    int          seq[6] = '{0, 1, 4, 5, 6, 7};
    logic [3:0]  t_idx[6] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7};
    logic [3:0]  t_nib[6] = '{4'h3, 4'hC, 4'h9, 4'hF, 4'hA, 4'h5};
    logic        t_pos[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit          m_scan[2];
    int          m_t[2];
    logic [23:0] m_act[2], m_pd[2];
    bit          m_pv[2];
    logic [3:0]  e_idx[2], e_nib[2];
    logic        e_pos[2], e_fd[2], e_rdy[2];

    function automatic logic [3:0] ref_nib(int d, logic [23:0] v);
        logic [7:0] byt;
        byt = d < 2 ? v[23:16] : d < 6 ? v[15:8] : v[7:0];
        return d % 2 == 0 ? byt[7:4] : byt[3:0];
    endfunction

    task automatic model_edge(int i);
        int f, d;
        bit bnd, ent, rdy;
        if (reset) begin
            m_scan[i] = 0; m_t[i] = 0; m_act[i] = '0; m_pd[i] = '0; m_pv[i] = 0;
            e_idx[i] = 4'd2; e_nib[i] = 4'd0; e_pos[i] = 1'b0; e_fd[i] = 1'b0; e_rdy[i] = 1'b1;
        end else begin
            f = 6 * div[i];
            bnd = m_scan[i] && m_t[i] % f == f - 1;
            ent = !m_scan[i] && enable;
            rdy = !m_pv[i];
            d = seq[(m_t[i] / div[i]) % 6];
            e_idx[i] = m_scan[i] ? 4'(d) : 4'd2;
            e_nib[i] = m_scan[i] ? ref_nib(d, m_act[i]) : 4'd0;
            e_pos[i] = m_scan[i] && d >= 6;
            e_fd[i] = bnd;
            if ((ent || bnd) && m_pv[i]) begin
                m_act[i] = m_pd[i];
                m_pv[i] = 0;
            end
            if (load_valid && rdy) begin
                m_pd[i] = {op_a, op_b, result};
                m_pv[i] = 1;
            end
            e_rdy[i] = !m_pv[i];
            if (ent) begin
                m_scan[i] = 1;
                m_t[i] = 0;
            end else if (bnd && !enable) m_scan[i] = 0;
            else if (m_scan[i]) m_t[i]++;
        end
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        chk("idx_div4", idx0, e_idx[0]);
        chk("nib_div4", nib0, e_nib[0]);
        chk("pos_div4", pos0, e_pos[0]);
        chk("fd_div4", fd0, e_fd[0]);
        chk("rdy_div4", rdy0, e_rdy[0]);
        chk("idx_div1", idx1, e_idx[1]);
        chk("nib_div1", nib1, e_nib[1]);
        chk("pos_div1", pos1, e_pos[1]);
        chk("fd_div1", fd1, e_fd[1]);
        chk("rdy_div1", rdy1, e_rdy[1]);
    endtask

    task automatic wait_idx(logic [3:0] tgt);
        bit hit;
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            cyc();
            hit = idx0 == tgt;
        end
        chk("wait_idx", hit, 1);
    endtask

    task automatic load(logic [7:0] a, logic [7:0] b, logic [7:0] r);
        op_a = a; op_b = b; result = r;
        load_valid = 1;
        cyc();
        load_valid = 0;
    endtask

    initial begin
        int c0, c1;
        reset = 1; enable = 0; load_valid = 0; op_a = 0; op_b = 0; result = 0;
        repeat (3) cyc();
        chk("rst_idx", idx0, 4'd2);
        chk("rst_nib", nib0, 4'd0);
        chk("rst_rdy", rdy0, 1'b1);
        chk("rst_fd", fd0, 1'b0);
        reset = 0;
        cyc();
        load(8'h3C, 8'h9F, 8'hA5);
        chk("ready_drop", rdy0, 1'b0);
        enable = 1;
        cyc();
        for (int n = 1; n <= 24; n++) begin
            cyc();
            chk("seq_idx", idx0, t_idx[(n - 1) / 4]);
            chk("seq_nib", nib0, t_nib[(n - 1) / 4]);
            chk("seq_pos", pos0, t_pos[(n - 1) / 4]);
            chk("seq_fd", fd0, n == 24);
        end
        wait_idx(4'd4);
        load(8'h11, 8'h22, 8'h33);
        chk("rdy_pend", rdy0, 1'b0);
        repeat (60) cyc();
        wait_idx(4'd1);
        load(8'h44, 8'h55, 8'h66);
        op_a = 8'h77; op_b = 8'h88; result = 8'h99; load_valid = 1;
        repeat (3) cyc();
        chk("rdy_second", rdy0, 1'b0);
        load_valid = 0;
        repeat (60) cyc();
        wait_idx(4'd6);
        cyc();
        chk("first_kept", nib0, 4'h6);
        wait_idx(4'd1);
        enable = 0;
        repeat (40) cyc();
        chk("idle_idx", idx0, 4'd2);
        chk("idle_nib", nib0, 4'd0);
        enable = 1;
        wait_idx(4'd4);
        load(8'hAB, 8'hCD, 8'hEF);
        wait_idx(4'd5);
        reset = 1;
        cyc();
        reset = 0;
        chk("abort_idx", idx0, 4'd2);
        chk("abort_rdy", rdy0, 1'b1);
        chk("abort_fd", fd0, 1'b0);
        repeat (2) cyc();
        chk("reenter_idx", idx0, 4'd0);
        chk("reenter_nib", nib0, 4'd0);
        repeat (12) cyc();
        c0 = 0; c1 = 0;
        for (int n = 0; n < 120; n++) begin
            cyc();
            c0 += int'(fd0);
            c1 += int'(fd1);
        end
        chk("fd_rate_div4", 8'(c0), 8'd5);
        chk("fd_rate_div1", 8'(c1), 8'd20);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            load_valid = $urandom_range(0, 7) == 0;
            op_a = 8'($urandom);
            op_b = 8'($urandom);
            result = 8'($urandom);
            reset = $urandom_range(0, 499) == 0;
            cyc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
